lvds_tx_scheduler: RTL and testbench
====================================

# lvds_tx_scheduler

Round-robin scheduler that shares one LVDS serial transmit line among `N_REQ` word sources. It grants one requester at a time and latches its `CH_NUM*8`-bit word. It then drives the framed serial stream: start bit 0, data LSB first, stop level 1, then a programmable idle gap. The block sits on the TX side of the link, and its `tx` output is directly compatible with the in-house serial receiver used for loopback self-check.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 1..16.
- `GAP`, default 2: extra idle-high cycles after the stop level, 0..255.
- `W` is not a parameter: it is fixed at `` `CH_NUM*8 `` from `params.vh`.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: per-requester transmit request, level-sensitive.
- `data_in`  in  N_REQ*W: requester i's word is slice `[i*W +: W]`.
- `ack`  out  N_REQ: one-cycle pulse marking the edge at which requester i's word was latched.
- `grant_id`  out  $clog2(max(N_REQ,2)): index of the requester being transmitted. Valid while `busy`=1.
- `busy`  out  1: high from the start bit through the last gap cycle.
- `tx`  out  1: serial line. Idles high.

## Operation

- FSM states: IDLE, START, DATA, STOP, GAP. All outputs are registered.
- IDLE
  - `tx`=1, `busy`=0.
  - If any `req` bit is set, select the first set bit searching upward from `ptr`, wrapping modulo `N_REQ`.
  - On that edge: latch the selected word into shift register `sft`, set `grant_id`, pulse `ack[g]`=1 for one cycle, set `ptr`=(g+1) mod `N_REQ`, drive `tx`=0, go to START.
- START: one cycle with `tx`=0, then go to DATA.
- DATA: W cycles. `tx`=`sft[0]`, shift right each cycle. A bit counter (width $clog2(W+1)) counts 0..W-1, then go to STOP.
- STOP: exactly 2 cycles with `tx`=1. The link receiver samples the stop level one cycle after the last data bit.
- GAP: `GAP` cycles with `tx`=1, then go to IDLE. When `GAP`=0, skip GAP and go from STOP directly to IDLE.
- Requester handshake:
  - Requester i holds `req[i]` and `data_in` stable until it sees `ack[i]`.
  - Data is sampled on the `ack` edge only.
  - Dropping `req` before grant withdraws the request, with no ack.
  - `req` changes while `busy`=1 have no effect on the frame in flight.
  - `req[i]` still high the cycle after `ack[i]` counts as a new request.
- Fairness: any continuously requesting source is served within `N_REQ` frames.
- With `N_REQ`=1, `ptr` stays 0.

## Timing

- Reset values: `tx`=1, `busy`=0, `ack`=0, `grant_id`=0, `ptr`=0, state IDLE, `sft`=0, counters 0.
- Reset takes priority over everything. A reset mid-frame forces `tx`=1 on the next cycle and the frame is abandoned. The ack for that frame has already been issued and is not repeated.
- Grant edge e (in IDLE with a request present):
  - `ack` and `busy` are high in cycle e+1.
  - Start bit is in cycle e+1.
  - Data bit i is in cycle e+2+i.
  - Stop level is in cycles e+W+2 and e+W+3.
  - Gap cycles follow, then one IDLE cycle.
- Back-to-back frame period: W+4+GAP cycles. Minimum high time between frames: 3+GAP cycles.
- Simultaneous requests resolve in a single cycle. Arbitration uses no extra latency.

## Structure

- `params.vh` (shared): `CH_NUM` plus the new FSM state encodings `LTX_IDLE`..`LTX_GAP` and the stop length constant `LTX_STOP_LEN`=2.
- Sub-module `rr_arbiter`, parameter `N_REQ`:
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and `gnt_id`.
  - Purely combinational priority rotate, reusable elsewhere.
- The FSM, shift register and counters live in `lvds_tx_scheduler`.

## Test plan

All scenarios use `CH_NUM`=1 (W=8), `N_REQ`=4, `GAP`=2.

- Single frame: reset, then `req[0]`=1 with `8'hA5`.
  - `ack[0]` pulses once.
  - `tx` sequence is 0, 1,0,1,0,0,1,0,1, 1,1, 1,1, then stays high.
  - `grant_id`=0 and `busy` is high for 13 cycles.
- Round-robin: hold all four `req` high with words `8'h11`/`8'h22`/`8'h33`/`8'h44`.
  - Grant order is 0,1,2,3,0.
  - Start bits are exactly 14 cycles apart.
- Wrap priority: after a grant to 3, assert `req[0]` and `req[3]` together. Grant goes to 0. A following lone `req[3]` is granted next.
- Loopback: feed `tx` into the receiver and send 256 random words from random requesters.
  - Every word is reproduced on the receiver output with its valid strobe.
  - There are no spurious strobes.
- Reset mid-DATA (cycle e+5):
  - `tx`=1 and `busy`=0 on the next cycle.
  - `ptr`=0.
  - No further ack.
  - The receiver produces no valid strobe.
- Withdrawn request: pulse `req[2]` for one cycle while `busy`. It is never acked and `tx` stays high after the current frame.

Source files
------------

// File: rtl/lvds_tx_scheduler_pkg.sv
// Shared constants for the LVDS TX scheduler: word width, FSM encodings and stop length.
// The block's only source for CH_NUM and the LTX_* state codes.
package lvds_tx_scheduler_pkg;

  localparam int CH_NUM       = 1;
  localparam int W            = CH_NUM * 8;
  localparam int LTX_STOP_LEN = 2;

  typedef enum logic [2:0] {
    LTX_IDLE  = 3'd0,
    LTX_START = 3'd1,
    LTX_DATA  = 3'd2,
    LTX_STOP  = 3'd3,
    LTX_GAP   = 3'd4
  } ltx_state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lvds_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
// Returns a one-hot grant and its index; nothing is granted while en is low.
module rr_arbiter
  import lvds_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]      req,
  input  logic [idw(N_REQ)-1:0] ptr,
  input  logic                  en,
  output logic [N_REQ-1:0]      gnt,
  output logic [idw(N_REQ)-1:0] gnt_id
);

  localparam int IDW = idw(N_REQ);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lvds_tx_scheduler.sv
// Shares one LVDS serial TX line among N_REQ word sources, round-robin.
// Frame: start 0, W data bits LSB first, two stop highs, GAP idle highs.
module lvds_tx_scheduler
  import lvds_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*W-1:0]    data_in,
  output logic [N_REQ-1:0]      ack,
  output logic [idw(N_REQ)-1:0] grant_id,
  output logic                  busy,
  output logic                  tx
);

  localparam int             IDW       = idw(N_REQ);
  localparam int             BCW       = $clog2(W + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(LTX_STOP_LEN - 1);
  localparam logic [7:0]     GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  ltx_state_e       state_q;
  logic [W-1:0]     sft_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [7:0]       gap_cnt_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_id_q;
  logic [N_REQ-1:0] ack_q;
  logic             busy_q, tx_q;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic [W-1:0]     word_sel;
  logic [W-1:0]     words [N_REQ];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .en     (state_q == LTX_IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
    assign words[gi] = data_in[gi*W +: W];
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) word_sel = words[i];
    end
  end

  // Wraps to 0 past the last requester; with one requester this is always 0.
  assign ptr_d = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LTX_IDLE;
      sft_q      <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      ack_q <= '0;
      case (state_q)
        LTX_IDLE: begin
          if (|gnt) begin
            sft_q      <= word_sel;
            grant_id_q <= gnt_id;
            ack_q      <= gnt;
            ptr_q      <= ptr_d;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            state_q    <= LTX_START;
          end
        end
        LTX_START: begin
          tx_q    <= sft_q[0];
          sft_q   <= sft_q >> 1;
          state_q <= LTX_DATA;
        end
        // bit_cnt_q is the index of the bit currently on the line.
        LTX_DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= LTX_STOP;
          end else begin
            tx_q      <= sft_q[0];
            sft_q     <= sft_q >> 1;
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        LTX_STOP: begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_q <= '0;
            if (GAP == 0) begin
              busy_q  <= 1'b0;
              state_q <= LTX_IDLE;
            end else begin
              gap_cnt_q <= '0;
              state_q   <= LTX_GAP;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        LTX_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= LTX_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= LTX_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// Directed bench for lvds_tx_scheduler (W=8, N_REQ=4, GAP=2) with a loopback receiver model.
module tb_lvds_tx_scheduler;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*8-1:0] data_in = '0;
  logic [NR-1:0]   ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic            tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] rx_sh = '0;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lvds_tx_scheduler #(.N_REQ(NR), .GAP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tx       (tx)
  );

  // Loopback receiver: start low, 8 data bits LSB first, stop sampled one cycle after last bit.
  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt <= 8) begin
        rx_sh = {tx, rx_sh[7:1]};
      end else begin
        if (tx == 1'b1) rx_q.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input bit clr, output int gid, output int t);
    bit seen;
    seen = 1'b0;
    gid  = -1;
    t    = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen = 1'b1;
        t    = cyc;
        for (int k = 0; k < NR; k++) if (ack[k]) gid = k;
        chk("ack_onehot", $countones(ack), 1);
        if (clr) req[gid] = 1'b0;
        $display("ack req=%0d cyc=%0d", gid, t);
      end
    end
    chk("ack_seen", seen, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    int g, t, t_prev, n0, r, w, ackc, busyc, lowc;
    logic [15:0] txs;
    t_prev = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    rst = 1'b0;

    // Single frame 8'hA5 from requester 0
    n0 = rx_q.size();
    data_in[7:0] = 8'hA5;
    req = 4'b0001;
    txs = '0; ackc = 0; busyc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      txs[i] = tx;
      if (ack[0]) begin
        ackc++;
        chk("sf_ack_cycle", i, 0);
        req[0] = 1'b0;
      end
      if (busy) begin
        busyc++;
        chk("sf_gid", grant_id, 0);
      end
    end
    chk("sf_tx_seq", txs, 16'hFF4A);
    chk("sf_ack_count", ackc, 1);
    chk("sf_busy_len", busyc, 13);
    chk("sf_rx_count", rx_q.size() - n0, 1);
    if (rx_q.size() > n0) chk("sf_rx_word", rx_q[n0], 8'hA5);
    $display("frame single tx=%04h", txs);

    // Round-robin with all four requesting continuously
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    n0 = rx_q.size();
    data_in = 32'h44332211;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(1'b0, g, t);
      chk("rr_order", g, k % 4);
      if (k > 0) chk("rr_period", t - t_prev, 14);
      t_prev = t;
    end
    req = '0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("rr_rx_count", rx_q.size() - n0, 5);
    for (int k = 0; k < 5; k++)
      if (rx_q.size() > n0 + k) chk("rr_rx_word", rx_q[n0 + k], 8'h11 * ((k % 4) + 1));

    // Wrap priority: after grant 3, req[0] and req[3] together -> 0, then 3
    req = 4'b1000;
    wait_ack(1'b1, g, t); chk("wrap_first", g, 3);
    wait_idle();
    req = 4'b1001;
    wait_ack(1'b1, g, t); chk("wrap_zero", g, 0);
    wait_ack(1'b1, g, t); chk("wrap_three", g, 3);
    wait_idle();

    // Withdrawn request pulsed while busy
    data_in[15:8] = 8'h5A;
    req = 4'b0010;
    wait_ack(1'b1, g, t); chk("wd_gid", g, 1);
    repeat (3) @(negedge clk);
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    wait_idle();
    ackc = 0; lowc = 0; busyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != '0) ackc++;
      if (!tx) lowc++;
      if (busy) busyc++;
    end
    chk("wd_no_ack", ackc, 0);
    chk("wd_tx_high", lowc, 0);
    chk("wd_not_busy", busyc, 0);

    // Loopback: 256 random words from random requesters
    n0 = rx_q.size();
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      r = $urandom_range(0, 3);
      w = $urandom_range(0, 255);
      data_in[r*8 +: 8] = w[7:0];
      req[r] = 1'b1;
      exp_q.push_back(w[7:0]);
      wait_ack(1'b1, g, t);
      chk("lb_gid", g, r);
    end
    wait_idle();
    repeat (4) @(negedge clk);
    chk("lb_rx_count", rx_q.size() - n0, 256);
    for (int k = 0; k < 256; k++)
      if (rx_q.size() > n0 + k) chk("lb_rx_word", rx_q[n0 + k], exp_q[k]);

    // Reset during DATA at cycle e+5
    n0 = rx_q.size();
    data_in[23:16] = 8'h07;
    req = 4'b0100;
    wait_ack(1'b1, g, t); chk("rm_gid", g, 2);
    repeat (4) @(negedge clk);
    chk("rm_bit3", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_tx", tx, 1);
    chk("rm_busy", busy, 0);
    chk("rm_ptr", dut.ptr_q, 0);
    chk("rm_ack", ack, 0);
    @(negedge clk);
    rst = 1'b0;
    ackc = 0; lowc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack != '0) ackc++;
      if (!tx) lowc++;
    end
    chk("rm_no_ack", ackc, 0);
    chk("rm_tx_high", lowc, 0);
    chk("rm_no_strobe", rx_q.size() - n0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
